// File: rtl/sonic_tx_gearbox_fifo_if.sv
// Handshake and status bundle between the DMA-completion side, the TX gearbox
// staging buffer and the serial datapath consumer.
interface sonic_tx_gearbox_fifo_if #(
    parameter int INPUT_WIDTH  = 64,
    parameter int OUTPUT_WIDTH = 40,
    parameter int DEPTH        = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [INPUT_WIDTH-1:0]  wr_data;
    logic                    wr_valid;
    logic                    wr_ready;
    logic                    commit;
    logic                    flush;
    logic                    out_ena;
    logic [OUTPUT_WIDTH-1:0] data_out;
    logic                    data_valid;
    logic                    underrun;
    logic [AW:0]             used_words;
    logic [AW:0]             committed_words;
    logic                    empty;
    logic                    full;

    modport master (
        output wr_data, wr_valid, commit, flush, out_ena,
        input  wr_ready, data_out, data_valid, underrun,
               used_words, committed_words, empty, full
    );

    modport slave (
        input  wr_data, wr_valid, commit, flush, out_ena,
        output wr_ready, data_out, data_valid, underrun,
               used_words, committed_words, empty, full
    );
endinterface

// File: rtl/sonic_tx_gearbox_fifo.sv
// TX staging buffer with commit gating and an integrated INPUT_WIDTH->OUTPUT_WIDTH
// down-converting gearbox emitting LSB-first slices.
module sonic_tx_gearbox_fifo #(
    parameter int                      INPUT_WIDTH  = 64,
    parameter int                      OUTPUT_WIDTH = 40,
    parameter int                      DEPTH        = 16,
    parameter logic [OUTPUT_WIDTH-1:0] IDLE_PATTERN = {OUTPUT_WIDTH{1'b0}}
) (
    input logic                   clk,
    input logic                   reset,
    sonic_tx_gearbox_fifo_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int ACCW = INPUT_WIDTH + OUTPUT_WIDTH;
    localparam int CW   = $clog2(ACCW + 1);

    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] IW_C      = CW'(INPUT_WIDTH);
    localparam logic [CW-1:0] OW_C      = CW'(OUTPUT_WIDTH);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    logic [INPUT_WIDTH-1:0]  mem_r [DEPTH];
    logic [AW:0]             wr_ptr_r;
    logic [AW:0]             commit_ptr_r;
    logic [AW:0]             rd_ptr_r;
    logic [ACCW-1:0]         acc_r;
    logic [CW-1:0]           cnt_r;
    logic [OUTPUT_WIDTH-1:0] data_out_r;
    logic                    data_valid_r;
    logic                    underrun_r;

    logic [AW:0]             used_s;
    logic [AW:0]             committed_s;
    logic                    full_s;
    logic                    wr_accept_s;
    logic                    load_s;
    logic [ACCW-1:0]         acc_ld_s;
    logic [CW-1:0]           cnt_ld_s;
    logic                    emit_s;

    assign used_s      = wr_ptr_r - rd_ptr_r;
    assign committed_s = commit_ptr_r - rd_ptr_r;
    assign full_s      = (used_s == DEPTH_C);
    // Flush wins over a same-cycle write, so the write never touches storage.
    assign wr_accept_s = bus.wr_valid && !full_s && !bus.flush;
    assign load_s      = bus.out_ena && (cnt_r < OW_C) && (committed_s != {(AW+1){1'b0}});

    assign bus.wr_ready        = !full_s;
    assign bus.used_words      = used_s;
    assign bus.committed_words = committed_s;
    assign bus.empty           = (used_s == {(AW+1){1'b0}});
    assign bus.full            = full_s;
    assign bus.data_out        = data_out_r;
    assign bus.data_valid      = data_valid_r;
    assign bus.underrun        = underrun_r;

    // Accumulator after the optional load of the word at rd_ptr.
    always_comb begin
        acc_ld_s = acc_r;
        cnt_ld_s = cnt_r;
        if (load_s) begin
            acc_ld_s = acc_r | ({{OUTPUT_WIDTH{1'b0}}, mem_r[rd_ptr_r[AW-1:0]]} << cnt_r);
            cnt_ld_s = cnt_r + IW_C;
        end else begin
            acc_ld_s = acc_r;
            cnt_ld_s = cnt_r;
        end
        emit_s = (cnt_ld_s >= OW_C);
    end

    // Word storage; no reset needed since pointers gate every read.
    always_ff @(posedge clk) begin
        if (wr_accept_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= bus.wr_data;
        end
    end

    // Pointers, gearbox state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= {(AW+1){1'b0}};
            commit_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r     <= {(AW+1){1'b0}};
            acc_r        <= {ACCW{1'b0}};
            cnt_r        <= CNT_ZERO;
            data_out_r   <= IDLE_PATTERN;
            data_valid_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr_r     <= {(AW+1){1'b0}};
            commit_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r     <= {(AW+1){1'b0}};
            acc_r        <= {ACCW{1'b0}};
            cnt_r        <= CNT_ZERO;
            data_out_r   <= IDLE_PATTERN;
            data_valid_r <= 1'b0;
            underrun_r   <= 1'b0;
        end else begin
            if (wr_accept_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (bus.commit) begin
                commit_ptr_r <= wr_accept_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
            end
            if (bus.out_ena) begin
                if (load_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
                if (emit_s) begin
                    data_out_r   <= acc_ld_s[OUTPUT_WIDTH-1:0];
                    data_valid_r <= 1'b1;
                    underrun_r   <= 1'b0;
                    acc_r        <= acc_ld_s >> OUTPUT_WIDTH;
                    cnt_r        <= cnt_ld_s - OW_C;
                end else begin
                    // Starved: keep partial bits, flag only if a stream is in flight.
                    data_out_r   <= IDLE_PATTERN;
                    data_valid_r <= 1'b0;
                    underrun_r   <= (cnt_ld_s != CNT_ZERO);
                    acc_r        <= acc_ld_s;
                    cnt_r        <= cnt_ld_s;
                end
            end else begin
                data_valid_r <= 1'b0;
                underrun_r   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_sonic_tx_gearbox_fifo.sv
// Scoreboard bench: committed words are expanded into a bit-level reference
// stream, cut into 40-bit slices and compared against every valid output.
module tb_sonic_tx_gearbox_fifo;
    localparam int IW    = 64;
    localparam int OW    = 40;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;

    sonic_tx_gearbox_fifo_if #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .DEPTH(DEPTH)) bus ();

    sonic_tx_gearbox_fifo #(
        .INPUT_WIDTH (IW),
        .OUTPUT_WIDTH(OW),
        .DEPTH       (DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nvalid = 0;
    logic [IW-1:0]  wq [$];
    logic [OW-1:0]  exp_q [$];
    logic [127:0]   pend_bits;
    int             pend_cnt;
    logic [OW-1:0]  last_slice;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_clear();
        wq.delete();
        exp_q.delete();
        pend_bits = 128'd0;
        pend_cnt  = 0;
    endtask

    task automatic model_commit();
        while (wq.size() > 0) begin
            logic [127:0] w;
            w = {64'd0, wq.pop_front()};
            pend_bits = pend_bits | (w << pend_cnt);
            pend_cnt += IW;
            while (pend_cnt >= OW) begin
                exp_q.push_back(pend_bits[OW-1:0]);
                pend_bits = pend_bits >> OW;
                pend_cnt -= OW;
            end
        end
    endtask

    task automatic sample();
        if (bus.data_valid === 1'b1) begin
            nvalid++;
            last_slice = bus.data_out;
            if (exp_q.size() == 0) check_eq("unexpected_slice", 64'd1, 64'd0);
            else check_eq("slice", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
        end
    endtask

    // Inputs change at the falling edge; outputs are sampled at the next falling edge.
    task automatic drive(input logic wv, input logic [IW-1:0] wd, input logic cm,
                         input logic oe, input logic fl, output logic accepted);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.commit   = cm;
        bus.out_ena  = oe;
        bus.flush    = fl;
        accepted     = wv && bus.wr_ready && !fl;
        @(posedge clk);
        @(negedge clk);
        sample();
        if (fl) begin
            model_clear();
        end else begin
            if (accepted) wq.push_back(wd);
            if (cm) model_commit();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [IW-1:0] w0, w1;
        int n0, nacc;

        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.commit   = 1'b0;
        bus.flush    = 1'b0;
        bus.out_ena  = 1'b0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_dout",     {24'd0, bus.data_out}, 64'd0);
        check_eq("rst_dv",       bus.data_valid, 0);
        check_eq("rst_ur",       bus.underrun, 0);
        check_eq("rst_empty",    bus.empty, 1);
        check_eq("rst_full",     bus.full, 0);
        check_eq("rst_wr_ready", bus.wr_ready, 1);
        check_eq("rst_used",     bus.used_words, 0);
        reset = 1'b0;

        // Uncommitted words stay invisible to the gearbox.
        for (int i = 0; i < 5; i++) drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, acc);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t2_used",      bus.used_words, 5);
        check_eq("t2_committed", bus.committed_words, 0);
        check_eq("t2_dv",        bus.data_valid, 0);
        check_eq("t2_ur",        bus.underrun, 0);

        // Commit: five words make exactly eight back-to-back slices.
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
        check_eq("t3_dv_commit_cycle", bus.data_valid, 0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
            check_eq("t3_dv", bus.data_valid, 1);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t3_dv_end", bus.data_valid, 0);
        check_eq("t3_ur_end", bus.underrun, 0);
        check_eq("t3_empty",  bus.empty, 1);
        check_eq("t3_q",      exp_q.size(), 0);

        // Fill to full, refuse the 17th word, then drain 25 slices.
        for (int i = 0; i < 16; i++) drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, acc);
        check_eq("t4_full",     bus.full, 1);
        check_eq("t4_wr_ready", bus.wr_ready, 0);
        check_eq("t4_used",     bus.used_words, 16);
        drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, acc);
        check_eq("t4_extra_acc",  acc, 0);
        check_eq("t4_used_after", bus.used_words, 16);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
        for (int i = 0; i < 25; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
            check_eq("t4_dv", bus.data_valid, 1);
        end
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t4_dv_end", bus.data_valid, 0);
        check_eq("t4_ur",     bus.underrun, 1);
        check_eq("t4_empty",  bus.empty, 1);

        // Async reset mid-stream with 24 residual bits and pending words.
        drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, acc);
        drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t1_pre_ur",   bus.underrun, 1);
        check_eq("t1_pre_used", bus.used_words, 2);
        reset = 1'b1;
        #1;
        check_eq("t1_dout",     {24'd0, bus.data_out}, 64'd0);
        check_eq("t1_dv",       bus.data_valid, 0);
        check_eq("t1_ur",       bus.underrun, 0);
        check_eq("t1_used",     bus.used_words, 0);
        check_eq("t1_wr_ready", bus.wr_ready, 1);
        model_clear();
        @(negedge clk);
        reset = 1'b0;

        // Single committed word, starvation, then continuation.
        w0 = {$urandom, $urandom};
        w1 = {$urandom, $urandom};
        drive(1'b1, w0, 1'b1, 1'b1, 1'b0, acc);
        check_eq("t5_committed", bus.committed_words, 1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t5_dv0",    bus.data_valid, 1);
        check_eq("t5_slice0", {24'd0, last_slice}, {24'd0, w0[39:0]});
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t5_ur",     bus.underrun, 1);
        check_eq("t5_dv_gap", bus.data_valid, 0);
        drive(1'b1, w1, 1'b1, 1'b1, 1'b0, acc);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t5_dv1",    bus.data_valid, 1);
        check_eq("t5_slice1", {24'd0, last_slice}, {24'd0, w1[15:0], w0[63:40]});
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t5_q", exp_q.size(), 0);

        // Streaming through pointer wrap, then flush with a colliding write/commit.
        n0   = nvalid;
        nacc = 0;
        for (int c = 0; c < 300 && nacc < 40; c++) begin
            drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0, acc);
            if (acc) nacc++;
        end
        check_eq("t6_accepted", nacc, 40);
        check_eq("t6_slices",   (nvalid - n0) >= 20, 1);
        drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b1, 1'b1, acc);
        check_eq("t6_used",      bus.used_words, 0);
        check_eq("t6_committed", bus.committed_words, 0);
        check_eq("t6_dv",        bus.data_valid, 0);
        check_eq("t6_ur",        bus.underrun, 0);
        check_eq("t6_empty",     bus.empty, 1);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
        check_eq("t6_used_after", bus.used_words, 0);
        check_eq("t6_dv_after",   bus.data_valid, 0);
        check_eq("t6_ur_after",   bus.underrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sonic_tx_gearbox_fifo.md
Name: sonic_tx_gearbox_fifo

Overview:
Single-clock, parametrised TX staging buffer with an integrated down-converting gearbox. It accepts INPUT_WIDTH-bit words into a DEPTH-entry circular buffer and releases them only after an explicit commit, which gates on completion. It emits OUTPUT_WIDTH-bit slices LSB-first on every enabled cycle. It sits between the DMA completion path and the serial TX datapath, and adds commit gating, flush and starvation reporting.

Parameters:
INPUT_WIDTH, 64, buffer word width in bits; must be >= OUTPUT_WIDTH.
OUTPUT_WIDTH, 40, gearbox output slice width in bits.
DEPTH, 16, buffer depth in words; power of 2, >= 2. localparam AW = $clog2(DEPTH).
IDLE_PATTERN, 0, OUTPUT_WIDTH-bit value driven when no valid slice is available.

Ports:
clk  in  1  clock; all logic is on its rising edge
reset  in  1  asynchronous, active-high reset
wr_data  in  INPUT_WIDTH  word to buffer
wr_valid  in  1  write request
wr_ready  out  1  combinational !full; a write is accepted when wr_valid && wr_ready
commit  in  1  pulse; makes all accepted words readable
flush  in  1  synchronous discard of all buffer and gearbox state
out_ena  in  1  gearbox advance strobe
data_out  out  OUTPUT_WIDTH  registered output slice
data_valid  out  1  data_out holds real data this cycle
underrun  out  1  registered pulse on mid-stream starvation
used_words  out  AW+1  wr_ptr - rd_ptr
committed_words  out  AW+1  commit_ptr - rd_ptr
empty  out  1  used_words == 0
full  out  1  used_words == DEPTH

Behaviour:
- Pointers wr_ptr, commit_ptr and rd_ptr are AW+1 bits wide. The low AW bits address storage; the MSB disambiguates full from empty, so wrap-around is natural modulo 2^(AW+1).
- Reset (async): all pointers are 0 and the gearbox bit count cnt is 0. Outputs: data_out = IDLE_PATTERN, data_valid = 0, underrun = 0, empty = 1, full = 0, wr_ready = 1.
- Write: an accepted word is stored at wr_ptr and wr_ptr increments. A write while full is ignored and no state changes.
- Commit: commit_ptr <= wr_ptr plus the word accepted in the same cycle, if any. Committed words become visible to the gearbox in the next cycle.
- Storage is a register array with combinational read, so the gearbox load has no read latency.
- Gearbox state: accumulator acc (INPUT_WIDTH+OUTPUT_WIDTH bits) and cnt (number of valid bits, LSB-aligned).
- Each cycle with out_ena = 1:
  a) If cnt < OUTPUT_WIDTH and committed_words > 0, the word at rd_ptr is OR'd into acc starting at bit cnt, cnt += INPUT_WIDTH, and rd_ptr increments.
  b) If the resulting cnt >= OUTPUT_WIDTH, then data_out <= acc[OUTPUT_WIDTH-1:0], data_valid <= 1, acc shifts right by OUTPUT_WIDTH, and cnt -= OUTPUT_WIDTH.
  c) Otherwise data_out <= IDLE_PATTERN, data_valid <= 0, and underrun <= (cnt != 0). Partial bits are retained.
- At most one load per cycle is needed, because OUTPUT_WIDTH <= INPUT_WIDTH.
- out_ena = 0: no gearbox or read-pointer change; data_valid <= 0, underrun <= 0, data_out holds.
- Latency: from out_ena to data_out is 1 cycle. A word committed in cycle N can produce data_valid at the earliest at the end of cycle N+1.
- flush has the highest priority. All pointers and cnt become 0; next-cycle outputs equal reset values. A write or commit in the same cycle is dropped.
- Simultaneous write and read while full: wr_ready is low, so the write is refused even if a read occurs that cycle. There is no bypass.
- used_words, committed_words, empty and full are combinational from the pointers.

Test Plan:
1. Assert reset mid-stream with cnt = 24 -> data_out = IDLE_PATTERN (0), data_valid = 0, used_words = 0, wr_ready = 1 immediately, asynchronously.
2. Write 5 words W0..W4 with no commit, out_ena = 1 -> used_words = 5, committed_words = 0, data_valid = 0, underrun = 0.
3. Pulse commit, then hold out_ena = 1 -> exactly 8 consecutive valid slices: slice0 = W0[39:0], slice1 = {W1[15:0], W0[63:40]}, ..., slice7 = W4[63:24]. Then data_valid = 0, underrun = 0, empty = 1.
4. Write 16 words -> full = 1, wr_ready = 0, and a 17th write is ignored. Then commit and drain 16*64/40 = 25.6 slices -> 25 valid slices, and the next cycle shows underrun = 1.
5. Commit 1 word with out_ena = 1 -> one valid slice W0[39:0]. Next cycle: underrun = 1 with cnt = 24. Commit W1 -> next slice = {W1[15:0], W0[63:40]}.
6. Stream 40 words through pointer wrap, then assert flush together with a write and a commit -> used_words = 0 and data_valid = 0. Output is bit-exact before the flush.
